// File: rtl/coin_pkg.sv
// Shared types and constants for the coin judge: lane FSM states, BCD digit type
// and the points awarded per hit.
package coin_pkg;

    localparam int DEFAULT_NUM_LANES = 3;
    localparam int HIT_POINTS        = 1;
    localparam int BONUS_POINTS      = 2;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [2:0] {
        IDLE,
        APPROACH,
        WINDOW,
        HIT,
        MISS,
        DONE
    } lane_state_t;

endpackage

// File: rtl/coin_lane_judge.sv
// One lane: synchronises active/in-position/key, detects key presses and judges
// each coin exactly once as a hit or a miss.
module coin_lane_judge
    import coin_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_active,
    input  logic i_in_position,
    input  logic i_key,
    output logic o_hit_pulse,
    output logic o_miss_pulse,
    output logic o_coin_clear
);

    logic [SYNC_STAGES-1:0] active_sync_q;
    logic [SYNC_STAGES-1:0] pos_sync_q;
    logic [SYNC_STAGES-1:0] key_sync_q;
    logic                   key_prev_q;
    lane_state_t            state_q;
    logic                   hit_q;
    logic                   miss_q;
    logic                   clr_q;

    logic active_s;
    logic pos_s;
    logic key_s;
    logic press;

    assign active_s = active_sync_q[SYNC_STAGES-1];
    assign pos_s    = pos_sync_q[SYNC_STAGES-1];
    assign key_s    = key_sync_q[SYNC_STAGES-1];
    assign press    = key_s & ~key_prev_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            active_sync_q <= '0;
            pos_sync_q    <= '0;
            key_sync_q    <= '0;
            key_prev_q    <= 1'b0;
            state_q       <= IDLE;
            hit_q         <= 1'b0;
            miss_q        <= 1'b0;
            clr_q         <= 1'b0;
        end else if (i_clear) begin
            active_sync_q <= '0;
            pos_sync_q    <= '0;
            key_sync_q    <= '0;
            key_prev_q    <= 1'b0;
            state_q       <= IDLE;
            hit_q         <= 1'b0;
            miss_q        <= 1'b0;
            clr_q         <= 1'b0;
        end else begin
            active_sync_q <= {active_sync_q[SYNC_STAGES-2:0], i_active};
            pos_sync_q    <= {pos_sync_q[SYNC_STAGES-2:0], i_in_position};
            key_sync_q    <= {key_sync_q[SYNC_STAGES-2:0], i_key};
            key_prev_q    <= key_s;
            hit_q         <= 1'b0;
            miss_q        <= 1'b0;
            clr_q         <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (active_s) state_q <= APPROACH;
                end
                APPROACH: begin
                    if (!active_s)   state_q <= IDLE;
                    else if (pos_s)  state_q <= WINDOW;
                end
                // A press in the same cycle the window closes still counts as a hit.
                WINDOW: begin
                    if (press)           state_q <= HIT;
                    else if (!active_s)  state_q <= IDLE;
                    else if (!pos_s)     state_q <= MISS;
                end
                HIT: begin
                    hit_q   <= 1'b1;
                    clr_q   <= 1'b1;
                    state_q <= DONE;
                end
                MISS: begin
                    miss_q  <= 1'b1;
                    clr_q   <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    if (!active_s) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_hit_pulse  = hit_q;
    assign o_miss_pulse = miss_q;
    assign o_coin_clear = clr_q;

endmodule

// File: rtl/coin_judge.sv
// Coin judge top: per-lane judges plus BCD score, current combo and best combo.
// Score and combo update one cycle after the lane pulses.
module coin_judge
    import coin_pkg::*;
#(
    parameter int NUM_LANES      = DEFAULT_NUM_LANES,
    parameter int SCORE_DIGITS   = 4,
    parameter int COMBO_BONUS_TH = 10,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_clear,
    input  logic [NUM_LANES-1:0]      i_active,
    input  logic [NUM_LANES-1:0]      i_in_position,
    input  logic [NUM_LANES-1:0]      i_key,
    output logic [NUM_LANES-1:0]      o_hit_pulse,
    output logic [NUM_LANES-1:0]      o_miss_pulse,
    output logic [NUM_LANES-1:0]      o_coin_clear,
    output logic [4*SCORE_DIGITS-1:0] o_score,
    output logic [7:0]                o_combo,
    output logic [7:0]                o_max_combo
);

    localparam logic [4*SCORE_DIGITS-1:0] SCORE_MAX = {SCORE_DIGITS{4'h9}};

    logic [4*SCORE_DIGITS-1:0] score_q, score_d, score_sum;
    logic [7:0]                combo_q, combo_d;
    logic [7:0]                max_q, max_d;
    logic [7:0]                hit_cnt;
    logic [7:0]                pts;
    logic [7:0]                add_pts;
    logic [7:0]                carry;
    logic [7:0]                tmp;
    bcd_digit_t                digit;
    logic [8:0]                combo_sum;

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            coin_lane_judge #(
                .SYNC_STAGES (SYNC_STAGES)
            ) u_lane (
                .i_clk         (i_clk),
                .i_rst_n       (i_rst_n),
                .i_clear       (i_clear),
                .i_active      (i_active[gi]),
                .i_in_position (i_in_position[gi]),
                .i_key         (i_key[gi]),
                .o_hit_pulse   (o_hit_pulse[gi]),
                .o_miss_pulse  (o_miss_pulse[gi]),
                .o_coin_clear  (o_coin_clear[gi])
            );
        end
    endgenerate

    always_comb begin
        hit_cnt = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            hit_cnt = hit_cnt + 8'(o_hit_pulse[i]);
        end

        // Every lane hitting this cycle is scored against the pre-update combo.
        pts     = (combo_q >= 8'(COMBO_BONUS_TH)) ? 8'(BONUS_POINTS) : 8'(HIT_POINTS);
        add_pts = hit_cnt * pts;

        carry     = add_pts;
        tmp       = '0;
        digit     = '0;
        score_sum = '0;
        for (int d = 0; d < SCORE_DIGITS; d++) begin
            tmp   = 8'(score_q[4*d +: 4]) + carry;
            digit = bcd_digit_t'(tmp % 8'd10);
            score_sum[4*d +: 4] = digit;
            carry = tmp / 8'd10;
        end
        score_d = (carry != 8'd0) ? SCORE_MAX : score_sum;

        combo_sum = {1'b0, combo_q} + {1'b0, hit_cnt};
        if (|o_miss_pulse) begin
            combo_d = '0;
        end else begin
            combo_d = combo_sum[8] ? 8'hFF : combo_sum[7:0];
        end
        max_d = (combo_d > max_q) ? combo_d : max_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            score_q <= '0;
            combo_q <= '0;
            max_q   <= '0;
        end else if (i_clear) begin
            score_q <= '0;
            combo_q <= '0;
            max_q   <= '0;
        end else begin
            score_q <= score_d;
            combo_q <= combo_d;
            max_q   <= max_d;
        end
    end

    assign o_score     = score_q;
    assign o_combo     = combo_q;
    assign o_max_combo = max_q;

endmodule
